rf_mp_sb: RTL and testbench

Parametrised multi-port register file with an integrated scoreboard for the pipelined CPU core. Provides two combinational read ports, two synchronous write ports with fixed priority, optional write-to-read bypass, and per-register busy bits. Issue logic sets a busy bit; writeback clears it. Sits between the decode stage (reads, issue) and the writeback stage (writes).

---
 rtl/rf_pkg.sv | 22 ++
 rtl/rf_scoreboard.sv | 54 +++++
 rtl/rf_mp_sb.sv | 90 +++++++++
 tb/tb_rf_mp_sb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared helpers and types for the multi-port register file and its scoreboard.
package rf_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_AW     = clog2(DEF_NREGS);

    // Write-port bundle so the writeback stage can carry a port as one value.
    typedef struct packed {
        logic                  we;
        logic [DEF_AW-1:0]     wa;
        logic [DEF_DATA_W-1:0] wd;
    } wr_port_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: writes clear, issue sets (set wins), plus a registered
// popcount of the busy vector. Register 0 can never be busy.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS = 32,
    localparam int AW    = clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic          iss_v,
    input  logic [AW-1:0] iss_a,
    input  logic [AW-1:0] ra0,
    input  logic [AW-1:0] ra1,
    output logic          busy0,
    output logic          busy1,
    output logic [AW:0]   nbusy
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      nbusy_q, nbusy_d;

    always_comb begin
        busy_d = busy_q;
        if (we0) busy_d[wa0] = 1'b0;
        if (we1) busy_d[wa1] = 1'b0;
        // The new producer owns the register, so issue overrides a same-cycle clear.
        if (iss_v) busy_d[iss_a] = 1'b1;
        busy_d[0] = 1'b0;
        nbusy_d = '0;
        for (int i = 1; i < NREGS; i++) begin
            nbusy_d = nbusy_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            nbusy_q <= '0;
        end else begin
            busy_q  <= busy_d;
            nbusy_q <= nbusy_d;
        end
    end

    assign busy0 = busy_q[ra0];
    assign busy1 = busy_q[ra1];
    assign nbusy = nbusy_q;

endmodule

// File: rtl/rf_mp_sb.sv
// Two-read / two-write register file with optional write-to-read bypass and an
// attached busy scoreboard. Register 0 reads as zero and ignores writes.
module rf_mp_sb
    import rf_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 32,
    parameter  bit BYPASS = 1'b1,
    localparam int AW     = clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra0,
    input  logic [AW-1:0]     ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic              busy0,
    output logic              busy1,
    input  logic              we0,
    input  logic              we1,
    input  logic [AW-1:0]     wa0,
    input  logic [AW-1:0]     wa1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss_v,
    input  logic [AW-1:0]     iss_a,
    input  logic [AW-1:0]     dbg_a,
    output logic [DATA_W-1:0] dbg_d,
    output logic [AW:0]       nbusy
);

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    logic [AW-1:0]     ra   [2];
    logic [DATA_W-1:0] rd   [2];

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        rf_d = rf_q;
        if (we0 && wa0 != '0) rf_d[wa0] = wd0;
        if (we1 && wa1 != '0) rf_d[wa1] = wd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    assign ra[0] = ra0;
    assign ra[1] = ra1;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = rf_q[ra[p]];
            if (BYPASS && ra[p] != '0) begin
                if (we1 && wa1 == ra[p]) begin
                    rd[p] = wd1;
                end else if (we0 && wa0 == ra[p]) begin
                    rd[p] = wd0;
                end
            end
        end
    end

    assign rd0   = rd[0];
    assign rd1   = rd[1];
    assign dbg_d = rf_q[dbg_a];

    rf_scoreboard #(
        .NREGS (NREGS)
    ) u_sb (
        .clk   (clk),
        .rst   (rst),
        .we0   (we0),
        .wa0   (wa0),
        .we1   (we1),
        .wa1   (wa1),
        .iss_v (iss_v),
        .iss_a (iss_a),
        .ra0   (ra0),
        .ra1   (ra1),
        .busy0 (busy0),
        .busy1 (busy1),
        .nbusy (nbusy)
    );

endmodule

// File: tb/tb_rf_mp_sb.sv
// Randomised + directed bench for rf_mp_sb: the driver pushes predictions from a
// behavioural register-file model, a monitor pops and compares each cycle.
module tb_rf_mp_sb;
    import rf_pkg::*;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = clog2(NR);

    typedef struct packed {
        wr_port_t      w0;
        wr_port_t      w1;
        logic          iss_v;
        logic [AW-1:0] iss_a;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [AW-1:0] dbg_a;
    } stim_t;

    typedef struct packed {
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic [DW-1:0] dbg_d;
        logic          busy0;
        logic          busy1;
        logic [AW:0]   nbusy;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] ra0, ra1, wa0, wa1, iss_a, dbg_a;
    logic [DW-1:0] rd0, rd1, wd0, wd1, dbg_d;
    logic          busy0, busy1, we0, we1, iss_v;
    logic [AW:0]   nbusy;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    logic [DW-1:0] mem [NR];
    bit            busy_m [NR];

    always #5 clk = ~clk;

    rf_mp_sb #(
        .DATA_W (DW),
        .NREGS  (NR),
        .BYPASS (1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ra0   (ra0),
        .ra1   (ra1),
        .rd0   (rd0),
        .rd1   (rd1),
        .busy0 (busy0),
        .busy1 (busy1),
        .we0   (we0),
        .we1   (we1),
        .wa0   (wa0),
        .wa1   (wa1),
        .wd0   (wd0),
        .wd1   (wd1),
        .iss_v (iss_v),
        .iss_a (iss_a),
        .dbg_a (dbg_a),
        .dbg_d (dbg_d),
        .nbusy (nbusy)
    );

    function automatic stim_t idleStim(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                       input logic [AW-1:0] d);
        stim_t s;
        s = '0;
        s.ra0 = r0;
        s.ra1 = r1;
        s.dbg_a = d;
        return s;
    endfunction

    function automatic logic [DW-1:0] modelRead(input stim_t s, input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (s.w1.we && s.w1.wa == a) return s.w1.wd;
        if (s.w0.we && s.w0.wa == a) return s.w0.wd;
        return mem[a];
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        int   c;
        c = 0;
        for (int i = 0; i < NR; i++) c += int'(busy_m[i]);
        e.rd0   = modelRead(s, s.ra0);
        e.rd1   = modelRead(s, s.ra1);
        e.dbg_d = mem[s.dbg_a];
        e.busy0 = busy_m[s.ra0];
        e.busy1 = busy_m[s.ra1];
        e.nbusy = (AW+1)'(c);
        return e;
    endfunction

    task automatic modelUpdate(input stim_t s);
        if (s.w0.we && s.w0.wa != 0) mem[s.w0.wa] = s.w0.wd;
        if (s.w1.we && s.w1.wa != 0) mem[s.w1.wa] = s.w1.wd;
        if (s.w0.we) busy_m[s.w0.wa] = 1'b0;
        if (s.w1.we) busy_m[s.w1.wa] = 1'b0;
        if (s.iss_v && s.iss_a != 0) busy_m[s.iss_a] = 1'b1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR; i++) begin
            mem[i]    = '0;
            busy_m[i] = 1'b0;
        end
    endtask

    task automatic drive(input stim_t s);
        we0 = s.w0.we; wa0 = s.w0.wa; wd0 = s.w0.wd;
        we1 = s.w1.we; wa1 = s.w1.wa; wd1 = s.w1.wd;
        iss_v = s.iss_v; iss_a = s.iss_a;
        ra0 = s.ra0; ra1 = s.ra1; dbg_a = s.dbg_a;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        drive(s);
        exp_q.push_back(predict(s));
        if (!rst) modelUpdate(s);
    endtask

    // Reset lands mid-cycle, well before the next rising edge.
    task automatic applyAsyncReset(input stim_t s);
        @(negedge clk);
        drive(s);
        #2;
        rst = 1'b1;
        modelReset();
        exp_q.push_back(predict(s));
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst = 1'b0;
        drive(idleStim('0, '0, '0));
    endtask

    function automatic stim_t randStim();
        stim_t s;
        bit    narrow;
        narrow = ($urandom_range(3, 0) == 0);
        s.w0.we = $urandom_range(1, 0) == 1;
        s.w1.we = $urandom_range(1, 0) == 1;
        s.w0.wa = narrow ? AW'($urandom_range(3, 0)) : AW'($urandom_range(NR-1, 0));
        s.w1.wa = narrow ? AW'($urandom_range(3, 0)) : AW'($urandom_range(NR-1, 0));
        s.w0.wd = $urandom;
        s.w1.wd = $urandom;
        s.iss_v = $urandom_range(2, 0) == 0;
        s.iss_a = narrow ? AW'($urandom_range(3, 0)) : AW'($urandom_range(NR-1, 0));
        s.ra0   = narrow ? AW'($urandom_range(3, 0)) : AW'($urandom_range(NR-1, 0));
        s.ra1   = narrow ? AW'($urandom_range(3, 0)) : AW'($urandom_range(NR-1, 0));
        s.dbg_a = AW'($urandom_range(NR-1, 0));
        return s;
    endfunction

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("rd0",   rd0,   e.rd0);
        cmp("rd1",   rd1,   e.rd1);
        cmp("dbg_d", dbg_d, e.dbg_d);
        cmp("busy0", DW'(busy0), DW'(e.busy0));
        cmp("busy1", DW'(busy1), DW'(e.busy1));
        cmp("nbusy", DW'(nbusy), DW'(e.nbusy));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        stim_t s;
        modelReset();
        drive(idleStim('0, '0, '0));
        #1 rst = 1'b1;

        applyStimulus(idleStim(5'd3, 5'd9, 5'd4));
        s = idleStim(5'd4, 5'd0, 5'd4);
        s.w1 = '{we: 1'b1, wa: 5'd4, wd: 32'hCAFEF00D};
        applyStimulus(s);
        releaseReset();

        for (int a = 0; a < NR; a++) applyStimulus(idleStim(AW'(a), AW'(NR-1-a), AW'(a)));

        s = idleStim(5'd5, 5'd0, 5'd5);
        s.w0 = '{we: 1'b1, wa: 5'd5, wd: 32'hDEADBEEF};
        applyStimulus(s);
        applyStimulus(idleStim(5'd5, 5'd5, 5'd5));
        s = idleStim(5'd0, 5'd0, 5'd0);
        s.w0 = '{we: 1'b1, wa: 5'd0, wd: 32'h00001234};
        applyStimulus(s);
        applyStimulus(idleStim(5'd0, 5'd0, 5'd0));

        s = idleStim(5'd0, 5'd7, 5'd7);
        s.w0 = '{we: 1'b1, wa: 5'd7, wd: 32'h11111111};
        s.w1 = '{we: 1'b1, wa: 5'd7, wd: 32'h22222222};
        applyStimulus(s);
        applyStimulus(idleStim(5'd7, 5'd7, 5'd7));

        s = idleStim(5'd3, 5'd0, 5'd3);
        s.iss_v = 1'b1; s.iss_a = 5'd3;
        applyStimulus(s);
        applyStimulus(idleStim(5'd3, 5'd0, 5'd3));
        s = idleStim(5'd3, 5'd3, 5'd3);
        s.w0 = '{we: 1'b1, wa: 5'd3, wd: 32'h33333333};
        applyStimulus(s);
        applyStimulus(idleStim(5'd3, 5'd3, 5'd3));
        s = idleStim(5'd3, 5'd3, 5'd3);
        s.w1 = '{we: 1'b1, wa: 5'd3, wd: 32'h44444444};
        s.iss_v = 1'b1; s.iss_a = 5'd3;
        applyStimulus(s);
        applyStimulus(idleStim(5'd3, 5'd3, 5'd3));
        applyStimulus(idleStim(5'd3, 5'd3, 5'd3));

        for (int r = 1; r < NR; r++) begin
            s = idleStim(AW'(r), AW'(r-1), AW'(r));
            s.iss_v = 1'b1; s.iss_a = AW'(r);
            applyStimulus(s);
        end
        applyStimulus(idleStim(5'd31, 5'd1, 5'd31));
        s = idleStim(5'd0, 5'd0, 5'd0);
        s.iss_v = 1'b1; s.iss_a = 5'd0;
        applyStimulus(s);
        applyStimulus(idleStim(5'd0, 5'd0, 5'd0));

        s = idleStim(5'd9, 5'd9, 5'd9);
        s.w0 = '{we: 1'b1, wa: 5'd9, wd: 32'h0000ABCD};
        s.iss_v = 1'b1; s.iss_a = 5'd9;
        applyStimulus(s);
        applyStimulus(idleStim(5'd9, 5'd9, 5'd9));
        applyAsyncReset(idleStim(5'd9, 5'd9, 5'd9));
        applyStimulus(idleStim(5'd9, 5'd3, 5'd9));
        releaseReset();

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                applyAsyncReset(randStim());
                applyStimulus(randStim());
                releaseReset();
            end else begin
                applyStimulus(randStim());
            end
        end
        applyStimulus(idleStim(5'd1, 5'd2, 5'd3));

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("[TB] FAIL watchdog: time %0t reached, expected completion earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
